mips_instr_encoder: RTL
=======================

// Module: mips_instr_encoder
// PURPOSE
//  Inverse of the main-decoder/ALU-decoder path: packs a decoded micro-op (kind, ALU control,
//  register fields, immediate) into a 32-bit MIPS instruction word. Sits between the test-program
//  generator / instruction-memory loader and imem. Output is buffered in a small FIFO with
//  valid/ready on both sides. Decoding its output must reproduce the ALU control it was given.
// PARAMETERS
//  DEPTH  2   output FIFO entries (power of two, >=2)
//  CNT_W  16  width of emitted-word counter
// PORTS
//  iClk         in   1   clock, all state on rising edge
//  iReset       in   1   asynchronous, active-high reset
//  iInValid     in   1   micro-op present
//  oInReady     out  1   encoder can accept (FIFO not full)
//  iKind        in   2   00 lw, 01 sw, 10 R-type, 11 illegal
//  iALUControl  in   3   ALU control code (R-type only; ignored for lw/sw)
//  iRs,iRt,iRd  in   5   register fields (iRd ignored for lw/sw)
//  iImm         in   16  immediate (ignored for R-type)
//  oOutValid    out  1   oInstr valid
//  iOutReady    in   1   consumer takes word
//  oInstr       out  32  encoded instruction (FIFO head)
//  oIllegal     out  1   sticky: an illegal micro-op was accepted and dropped
//  oCount       out  CNT_W  words emitted (out handshakes), wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, active-high): FIFO empty, oOutValid=0, oIllegal=0, oCount=0, oInstr=0;
//   oInReady=1 once reset deasserts. Reset mid-transfer discards all buffered words.
//  Input accept = iInValid & oInReady. Output handshake = oOutValid & iOutReady.
//  Encoding: lw {100011,rs,rt,imm}; sw {101011,rs,rt,imm};
//   R-type {000000,rs,rt,rd,5'b0,funct}; funct from iALUControl: 010->100000 add,
//   110->100010 sub, 000->100100 and, 001->100101 or, 111->101010 slt.
//  Illegal: iKind=11, or R-type with iALUControl in {011,100,101}. Illegal op is accepted
//   (consumes handshake), NOT pushed, sets oIllegal next edge; oIllegal holds until reset.
//  Latency: accepted legal op visible on oInstr/oOutValid the cycle after accept (no bypass).
//  oInReady = !full; combinational only in FIFO occupancy, never on iOutReady (no ready path).
//   Full + simultaneous pop: no push that cycle; push on the next cycle.
//  Empty: oOutValid=0, oInstr holds last value (don't-care). Push+pop same cycle with
//   occupancy 1..DEPTH-1: occupancy unchanged, order preserved.
//  oCount increments on every output handshake; all-ones wraps to 0.
//  Inputs need only be stable while iInValid=1; oInstr stable while oOutValid & !iOutReady.
// CONFIGURATION
//  ENC_BYPASS_EN defined: FIFO empty & accept & iOutReady -> word goes straight to oInstr
//   with oOutValid=1 in the same cycle (zero latency); FIFO not written; oCount still increments.
//   Illegal op never bypasses (oOutValid stays 0).
//  Not defined: always one cycle latency through the FIFO as above.
// STRUCTURE
//  mips_pkg: opcode localparams (OP_LW, OP_SW, OP_RTYPE), funct localparams, ALU control codes,
//   typedef enum logic [1:0] kind_t {KIND_LW, KIND_SW, KIND_RTYPE, KIND_ILL}.
//  Sub-module sync_fifo #(WIDTH=32, DEPTH): pointer-based, full/empty flags, async reset.
//  Encoder function (combinational) lives in this module, using package constants.
// TESTING
//  1 lw rs=2 rt=5 imm=0x0010 -> oInstr=0x8C450010 one cycle after accept; oCount=1 after pop.
//  2 R-type add rs=1 rt=2 rd=3 (ALU 010) -> 0x00221820; sub (110) same regs -> 0x00221822.
//  3 iOutReady=0, push 3 ops with DEPTH=2 -> oInReady=0 after 2nd; release -> order kept,
//   3rd accepted only after first pop.
//  4 R-type ALU 011 then kind 11 -> nothing pushed, oIllegal=1 and stays 1; next legal sw
//   rs=0 rt=8 imm=0x0004 -> 0xAC080004.
//  5 Reset asserted with 2 buffered words -> oOutValid=0, oCount=0, oIllegal=0 immediately.
//  6 ENC_BYPASS_EN, empty FIFO, iOutReady=1, or rs=4 rt=5 rd=6 -> 0x00853025 same cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and micro-op types for the instruction encoder.
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {KIND_LW, KIND_SW, KIND_RTYPE, KIND_ILL} kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [2:0]  alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } uop_t;

  typedef struct packed {
    logic        ill;
    logic [31:0] word;
  } enc_t;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Micro-op in / instruction word out handshake bundle for mips_instr_encoder.
interface mips_instr_encoder_if #(parameter int CNT_W = 16);
  logic              iInValid;
  logic              oInReady;
  logic [1:0]        iKind;
  logic [2:0]        iALUControl;
  logic [4:0]        iRs;
  logic [4:0]        iRt;
  logic [4:0]        iRd;
  logic [15:0]       iImm;
  logic              oOutValid;
  logic              iOutReady;
  logic [31:0]       oInstr;
  logic              oIllegal;
  logic [CNT_W-1:0]  oCount;

  modport slave (
    input  iInValid, iKind, iALUControl, iRs, iRt, iRd, iImm, iOutReady,
    output oInReady, oOutValid, oInstr, oIllegal, oCount
  );

  modport master (
    output iInValid, iKind, iALUControl, iRs, iRt, iRd, iImm, iOutReady,
    input  oInReady, oOutValid, oInstr, oIllegal, oCount
  );
endinterface

// File: rtl/mips_instr_encoder_sync_fifo.sv
// Pointer-based synchronous FIFO; extra pointer MSB separates full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign oEmpty = (wr_ptr_q == rd_ptr_q);
  assign oFull  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign oData  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (iPush && !oFull) begin
      mem_d[wr_ptr_q[AW-1:0]] = iData;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (iPop && !oEmpty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// Packs decoded micro-ops into MIPS words behind an output FIFO.
// Optional ENC_BYPASS_EN: empty FIFO + ready consumer forwards the word in the accept cycle.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 iClk,
  input  logic                 iReset,
  mips_instr_encoder_if.slave  bus
);

  function automatic enc_t encode(input uop_t u);
    enc_t e;
    e.ill  = 1'b0;
    e.word = '0;
    case (u.kind)
      KIND_LW:    e.word = {OP_LW, u.rs, u.rt, u.imm};
      KIND_SW:    e.word = {OP_SW, u.rs, u.rt, u.imm};
      KIND_RTYPE: begin
        case (u.alu)
          ALU_ADD: e.word = {OP_RTYPE, u.rs, u.rt, u.rd, 5'b0, FN_ADD};
          ALU_SUB: e.word = {OP_RTYPE, u.rs, u.rt, u.rd, 5'b0, FN_SUB};
          ALU_AND: e.word = {OP_RTYPE, u.rs, u.rt, u.rd, 5'b0, FN_AND};
          ALU_OR:  e.word = {OP_RTYPE, u.rs, u.rt, u.rd, 5'b0, FN_OR};
          ALU_SLT: e.word = {OP_RTYPE, u.rs, u.rt, u.rd, 5'b0, FN_SLT};
          default: e.ill  = 1'b1;
        endcase
      end
      default:    e.ill = 1'b1;
    endcase
    return e;
  endfunction

  uop_t             uop;
  enc_t             enc;
  logic             full, empty, accept, push, pop, bypass, out_hs;
  logic [31:0]      head;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    uop = '{kind: kind_t'(bus.iKind), alu: bus.iALUControl, rs: bus.iRs,
            rt: bus.iRt, rd: bus.iRd, imm: bus.iImm};
    enc = encode(uop);
  end

  assign accept = bus.iInValid & ~full;
`ifdef ENC_BYPASS_EN
  assign bypass = accept & empty & ~enc.ill & bus.iOutReady;
`else
  assign bypass = 1'b0;
`endif
  assign push   = accept & ~enc.ill & ~bypass;
  assign pop    = ~empty & bus.iOutReady;
  assign out_hs = bus.oOutValid & bus.iOutReady;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .iClk   (iClk),
    .iReset (iReset),
    .iPush  (push),
    .iData  (enc.word),
    .iPop   (pop),
    .oData  (head),
    .oFull  (full),
    .oEmpty (empty)
  );

  // Ready depends only on occupancy so no combinational path from iOutReady.
  assign bus.oInReady  = ~full;
  assign bus.oOutValid = ~empty | bypass;
  assign bus.oInstr    = bypass ? enc.word : head;
  assign bus.oIllegal  = ill_q;
  assign bus.oCount    = cnt_q;

  always_comb begin
    ill_d = ill_q | (accept & enc.ill);
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, out_hs};
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ill_q <= ill_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
